// File: rtl/cordic_fsm_control_if.sv
// Control/status bundle between the CORDIC sequencer (master) and the
// datapath / FPU / request side (slave).
interface cordic_fsm_control_if #(
  parameter int unsigned D = 5
);
  logic         BEG_CORDIC;
  logic         ACK_SUM;
  logic         O_F;
  logic         U_F;
  logic [D-1:0] CONT_ITERA;
  logic         MS_1;
  logic [1:0]   MS_4;
  logic [1:0]   MS_2;
  logic [1:0]   MS_3;
  logic         EN_REG1X;
  logic         EN_REG1Y;
  logic         EN_REG1Z;
  logic         EN_REG2;
  logic         EN_REG2XYZ;
  logic         EN_REG3;
  logic         EN_REG4;
  logic         ADD_SUBT;
  logic         Begin_SUM;
  logic         CLK_CDIR;
  logic         BUSY;
  logic         RDY;
  logic         ERR_OVF;
  logic         ERR_TMO;

  modport master (
    input  BEG_CORDIC, ACK_SUM, O_F, U_F, CONT_ITERA,
    output MS_1, MS_4, MS_2, MS_3,
           EN_REG1X, EN_REG1Y, EN_REG1Z, EN_REG2, EN_REG2XYZ, EN_REG3, EN_REG4,
           ADD_SUBT, Begin_SUM, CLK_CDIR, BUSY, RDY, ERR_OVF, ERR_TMO
  );

  modport slave (
    output BEG_CORDIC, ACK_SUM, O_F, U_F, CONT_ITERA,
    input  MS_1, MS_4, MS_2, MS_3,
           EN_REG1X, EN_REG1Y, EN_REG1Z, EN_REG2, EN_REG2XYZ, EN_REG3, EN_REG4,
           ADD_SUBT, Begin_SUM, CLK_CDIR, BUSY, RDY, ERR_OVF, ERR_TMO
  );
endinterface

// File: rtl/cordic_fsm_control.sv
// CORDIC datapath sequencer: init, N_ITER micro-rotations, final capture and
// counter rewind, with FPU add/sub handshake, watchdog and sticky error flags.
module cordic_fsm_control #(
  parameter int unsigned N_ITER = 25,
  parameter int unsigned D      = 5,
  parameter int unsigned TMO    = 255
) (
  input  logic                 CLK,
  input  logic                 RST,
  cordic_fsm_control_if.master bus
);

  localparam int unsigned WDW     = $clog2(TMO + 1);
  localparam logic [D-1:0] LAST_IT = D'(N_ITER - 1);
  localparam logic [D-1:0] CNT_MAX = {D{1'b1}};

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_SETUP, S_START, S_WAIT,
    S_ROM_WAIT, S_LATCH, S_STEP, S_REWIND, S_DONE
  } state_e;

  typedef enum logic [2:0] {
    OP_INIT_X, OP_INIT_Y, OP_ROT_Z, OP_ROT_Y, OP_ROT_X, OP_FINAL
  } op_e;

  typedef enum logic [1:0] {DST_X, DST_Y, DST_Z, DST_R4} dst_e;

  typedef struct packed {
    logic [1:0] ms4;
    logic [1:0] ms2;
    logic [1:0] ms3;
    logic       add_subt;
    dst_e       dst;
  } op_t;

  // Per-op mux selects, FPU operation and destination register.
  function automatic op_t op_decode(input op_e op);
    op_t f;
    f = '0;
    case (op)
      OP_INIT_X: f = '{ms4: 2'b10, ms2: 2'b00, ms3: 2'b00, add_subt: 1'b0, dst: DST_X};
      OP_INIT_Y: f = '{ms4: 2'b10, ms2: 2'b00, ms3: 2'b00, add_subt: 1'b1, dst: DST_Y};
      OP_ROT_Z:  f = '{ms4: 2'b01, ms2: 2'b00, ms3: 2'b00, add_subt: 1'b0, dst: DST_Z};
      OP_ROT_Y:  f = '{ms4: 2'b01, ms2: 2'b01, ms3: 2'b01, add_subt: 1'b0, dst: DST_Y};
      OP_ROT_X:  f = '{ms4: 2'b01, ms2: 2'b10, ms3: 2'b10, add_subt: 1'b0, dst: DST_X};
      OP_FINAL:  f = '{ms4: 2'b00, ms2: 2'b00, ms3: 2'b00, add_subt: 1'b0, dst: DST_R4};
      default:   f = '0;
    endcase
    return f;
  endfunction

  state_e         state_q, state_d;
  op_e            op_q, op_d;
  logic [WDW-1:0] wdog_q, wdog_d;
  logic           err_ovf_q, err_ovf_d;
  logic           err_tmo_q, err_tmo_d;
  op_t            op_f;

  assign op_f        = op_decode(op_q);
  assign bus.ERR_OVF = err_ovf_q;
  assign bus.ERR_TMO = err_tmo_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      op_q      <= OP_INIT_X;
      wdog_q    <= '0;
      err_ovf_q <= 1'b0;
      err_tmo_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      wdog_q    <= wdog_d;
      err_ovf_q <= err_ovf_d;
      err_tmo_q <= err_tmo_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    wdog_d         = '0;
    err_ovf_d      = err_ovf_q;
    err_tmo_d      = err_tmo_q;
    bus.MS_1       = 1'b0;
    bus.MS_4       = 2'b00;
    bus.MS_2       = 2'b00;
    bus.MS_3       = 2'b00;
    bus.EN_REG1X   = 1'b0;
    bus.EN_REG1Y   = 1'b0;
    bus.EN_REG1Z   = 1'b0;
    bus.EN_REG2    = 1'b0;
    bus.EN_REG2XYZ = 1'b0;
    bus.EN_REG3    = 1'b0;
    bus.EN_REG4    = 1'b0;
    bus.ADD_SUBT   = 1'b0;
    bus.Begin_SUM  = 1'b0;
    bus.CLK_CDIR   = 1'b0;
    bus.RDY        = 1'b0;
    bus.BUSY       = (state_q != S_IDLE);

    // Selects held steady for the whole life of an FPU op.
    if (state_q inside {S_SETUP, S_START, S_WAIT}) begin
      bus.MS_4     = op_f.ms4;
      bus.MS_2     = op_f.ms2;
      bus.MS_3     = op_f.ms3;
      bus.ADD_SUBT = op_f.add_subt;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.BEG_CORDIC && (bus.CONT_ITERA == '0)) begin
          err_ovf_d = 1'b0;
          err_tmo_d = 1'b0;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        bus.EN_REG3  = 1'b1;
        bus.MS_1     = 1'b1;
        bus.EN_REG1Z = 1'b1;
        op_d         = OP_INIT_X;
        state_d      = S_SETUP;
      end
      S_SETUP: begin
        bus.EN_REG2XYZ = 1'b1;
        state_d        = S_START;
      end
      S_START: begin
        bus.Begin_SUM = 1'b1;
        state_d       = S_WAIT;
      end
      S_WAIT: begin
        if (bus.ACK_SUM) begin
          bus.EN_REG1X = (op_f.dst == DST_X);
          bus.EN_REG1Y = (op_f.dst == DST_Y);
          bus.EN_REG1Z = (op_f.dst == DST_Z);
          bus.EN_REG4  = (op_f.dst == DST_R4);
          if (bus.O_F || bus.U_F) err_ovf_d = 1'b1;
          case (op_q)
            OP_INIT_X: begin op_d = OP_INIT_Y; state_d = S_SETUP; end
            OP_INIT_Y: state_d = S_ROM_WAIT;
            OP_ROT_Z:  begin op_d = OP_ROT_Y; state_d = S_SETUP; end
            OP_ROT_Y:  begin op_d = OP_ROT_X; state_d = S_SETUP; end
            OP_ROT_X:  state_d = S_STEP;
            OP_FINAL:  state_d = S_REWIND;
            default:   state_d = S_IDLE;
          endcase
        end else if (wdog_q == WDW'(TMO - 1)) begin
          err_tmo_d = 1'b1;
          state_d   = S_REWIND;
        end else begin
          wdog_d = wdog_q + WDW'(1);
        end
      end
      S_ROM_WAIT: state_d = S_LATCH;
      S_LATCH: begin
        bus.EN_REG2 = 1'b1;
        op_d        = OP_ROT_Z;
        state_d     = S_SETUP;
      end
      S_STEP: begin
        bus.CLK_CDIR = 1'b1;
        if (bus.CONT_ITERA == LAST_IT) begin
          op_d    = OP_FINAL;
          state_d = S_SETUP;
        end else begin
          state_d = S_ROM_WAIT;
        end
      end
      // Leave once the counter is zero or this pulse wraps it to zero.
      S_REWIND: begin
        bus.CLK_CDIR = (bus.CONT_ITERA != '0);
        if ((bus.CONT_ITERA == '0) || (bus.CONT_ITERA == CNT_MAX)) state_d = S_DONE;
      end
      S_DONE: begin
        bus.RDY = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cordic_fsm_control.sv
// Directed/randomized bench for cordic_fsm_control with FPU and counter models.
module tb_cordic_fsm_control;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cordic_fsm_control_if b4 ();
  cordic_fsm_control_if b32 ();

  cordic_fsm_control #(.N_ITER(4))  dut4  (.CLK(clk), .RST(rst), .bus(b4));
  cordic_fsm_control #(.N_ITER(32)) dut32 (.CLK(clk), .RST(rst), .bus(b32));

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath iteration counters (wrap at 32, cleared by reset).
  logic [4:0] cnt4, cnt32;
  bit         force7 = 1'b0;
  always @(posedge clk) begin
    if (rst)             cnt4 <= 5'd0;
    else if (force7)     cnt4 <= 5'd7;
    else if (b4.CLK_CDIR) cnt4 <= cnt4 + 5'd1;
    if (rst)              cnt32 <= 5'd0;
    else if (b32.CLK_CDIR) cnt32 <= cnt32 + 5'd1;
  end
  assign b4.CONT_ITERA  = cnt4;
  assign b32.CONT_ITERA = cnt32;

  // FPU model: ack on the fpu_w-th wait cycle after Begin_SUM, unless held.
  int   fpu_w  = 3;
  int   ovf_at = 0;
  bit   ovf_u  = 1'b0;
  bit   hold   = 1'b0;
  int   wcnt   = 0;
  bit   pend   = 1'b0;
  int   nack   = 0;
  logic fire4;
  assign fire4 = !rst && !hold &&
                 ((b4.Begin_SUM && fpu_w == 1) || (!b4.Begin_SUM && pend && (wcnt + 1 == fpu_w)));

  always @(posedge clk) begin
    if (rst) begin
      b4.ACK_SUM <= 1'b0; b4.O_F <= 1'b0; b4.U_F <= 1'b0;
      pend <= 1'b0; wcnt <= 0; nack <= 0;
    end else begin
      b4.ACK_SUM <= fire4;
      b4.O_F     <= fire4 && !ovf_u && (nack + 1 == ovf_at);
      b4.U_F     <= fire4 &&  ovf_u && (nack + 1 == ovf_at);
      if (b4.EN_REG3)  nack <= 0;
      else if (fire4)  nack <= nack + 1;
      if (b4.Begin_SUM) begin
        pend <= !hold && !fire4;
        wcnt <= 1;
      end else if (pend) begin
        if (hold || fire4) pend <= 1'b0;
        else               wcnt <= wcnt + 1;
      end
    end
  end

  always @(posedge clk) b32.ACK_SUM <= !rst && b32.Begin_SUM;
  assign b32.O_F = 1'b0;
  assign b32.U_F = 1'b0;

  // Event monitor for the N_ITER=4 instance.
  int nbeg = 0, ndest = 0, nreg2 = 0, ncdir = 0, nreg4 = 0, nrdy = 0, nreg3 = 0, nviol = 0;
  int ncdir32 = 0;
  logic [6:0] lsel [0:4095];
  logic [3:0] ldst [0:4095];
  logic [6:0] ssel = '0;
  logic [6:0] sel4;
  logic [3:0] dvec;
  assign sel4 = {b4.MS_4, b4.MS_2, b4.MS_3, b4.ADD_SUBT};
  assign dvec = {b4.EN_REG1X, b4.EN_REG1Y, b4.EN_REG1Z, b4.EN_REG4} & {4{!b4.MS_1}};

  always @(negedge clk) begin
    if (!rst) begin
      if (b4.Begin_SUM) nbeg  <= nbeg + 1;
      if (b4.EN_REG2)   nreg2 <= nreg2 + 1;
      if (b4.CLK_CDIR)  ncdir <= ncdir + 1;
      if (b4.EN_REG4)   nreg4 <= nreg4 + 1;
      if (b4.RDY)       nrdy  <= nrdy + 1;
      if (b4.EN_REG3)   nreg3 <= nreg3 + 1;
      if (b32.CLK_CDIR) ncdir32 <= ncdir32 + 1;
      if (|dvec) begin
        ndest <= ndest + 1;
        lsel[ndest % 4096] <= sel4;
        ldst[ndest % 4096] <= dvec;
      end
      if (b4.EN_REG2XYZ) ssel <= sel4;
      if ((b4.Begin_SUM && b4.ACK_SUM) || (b4.EN_REG2 && b4.CLK_CDIR) ||
          ((|dvec) && (($countones(dvec) != 1) || !b4.ACK_SUM || (sel4 != ssel))))
        nviol <= nviol + 1;
    end
  end

  int base_beg, base_dest, base_reg2, base_cdir, base_reg4, base_rdy, base_reg3, base_viol;

  task automatic snap();
    base_beg = nbeg;   base_dest = ndest; base_reg2 = nreg2; base_cdir = ncdir;
    base_reg4 = nreg4; base_rdy = nrdy;   base_reg3 = nreg3; base_viol = nviol;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [20:0] outs4();
    return {b4.MS_1, b4.MS_4, b4.MS_2, b4.MS_3, b4.EN_REG1X, b4.EN_REG1Y, b4.EN_REG1Z,
            b4.EN_REG2, b4.EN_REG2XYZ, b4.EN_REG3, b4.EN_REG4, b4.ADD_SUBT, b4.Begin_SUM,
            b4.CLK_CDIR, b4.BUSY, b4.RDY, b4.ERR_OVF, b4.ERR_TMO};
  endfunction

  // Cycles from the start-request cycle to the RDY cycle.
  function automatic int run_lat(input int n, input int w);
    int r;
    r = (32 - n > 1) ? 32 - n : 1;
    return 1 + 2 * (2 + w) + n * (3 + 3 * (2 + w)) + (2 + w) + r + 1;
  endfunction

  task automatic start4(output int t0);
    b4.BEG_CORDIC = 1'b1;
    t0 = cyc;
    @(negedge clk);
    b4.BEG_CORDIC = 1'b0;
  endtask

  task automatic wait_rdy4(input int bound, output int tr, output bit ok);
    ok = 1'b0;
    tr = -1;
    for (int i = 0; i < bound; i++) begin
      if (b4.RDY) begin ok = 1'b1; tr = cyc; break; end
      @(negedge clk);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0, tr, w;
    bit ok, prev;
    logic [6:0] s, es;
    logic [3:0] dd, ed;

    b4.BEG_CORDIC  = 1'b0;
    b32.BEG_CORDIC = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'(outs4()), 0);
    chk("reset_busy", b4.BUSY, 0);
    rst = 1'b0;
    @(negedge clk);

    // Nominal run, W=3, with an ignored start request mid-run.
    fpu_w = 3;
    snap();
    start4(t0);
    chk("load_en_reg3", b4.EN_REG3, 1);
    repeat ($urandom_range(5, 80)) @(negedge clk);
    b4.BEG_CORDIC = 1'b1;
    @(negedge clk);
    b4.BEG_CORDIC = 1'b0;
    wait_rdy4(5000, tr, ok);
    chk("nom_rdy_seen", ok, 1);
    chk("nom_latency", tr - t0, run_lat(4, 3));
    chk("nom_cnt_at_rdy", b4.CONT_ITERA, 0);
    @(negedge clk);
    chk("nom_begin_sum", nbeg - base_beg, 2 + 3 * 4 + 1);
    chk("nom_dest_en", ndest - base_dest, 2 + 3 * 4 + 1);
    chk("nom_en_reg2", nreg2 - base_reg2, 4);
    chk("nom_clk_cdir", ncdir - base_cdir, 4 + 28);
    chk("nom_en_reg4", nreg4 - base_reg4, 1);
    chk("nom_rdy_count", nrdy - base_rdy, 1);
    chk("nom_single_start", nreg3 - base_reg3, 1);
    chk("nom_invariants", nviol - base_viol, 0);
    chk("nom_idle_after", b4.BUSY, 0);
    chk("nom_err_ovf", b4.ERR_OVF, 0);
    s = lsel[(base_dest + 0) % 4096]; dd = ldst[(base_dest + 0) % 4096];
    chk("init_x_ms4", s[6:5], 2'b10); chk("init_x_add", s[0], 0); chk("init_x_dst", dd, 4'b1000);
    s = lsel[(base_dest + 1) % 4096]; dd = ldst[(base_dest + 1) % 4096];
    chk("init_y_ms4", s[6:5], 2'b10); chk("init_y_add", s[0], 1); chk("init_y_dst", dd, 4'b0100);
    for (int k = 0; k < 3; k++) begin
      s  = lsel[(base_dest + 5 + k) % 4096];
      dd = ldst[(base_dest + 5 + k) % 4096];
      es = {2'b01, 2'(k), 2'(k), 1'b0};
      ed = 4'b0010 << k;
      chk($sformatf("iter2_sel_%0d", k), s, es);
      chk($sformatf("iter2_dst_%0d", k), dd, ed);
    end
    s = lsel[(base_dest + 14) % 4096]; dd = ldst[(base_dest + 14) % 4096];
    chk("final_ms4", s[6:5], 2'b00); chk("final_dst", dd, 4'b0001);

    // Random ack latency, overflow/underflow on the 5th ack.
    w = $urandom_range(1, 6);
    fpu_w = w; ovf_at = 5; ovf_u = 1'($urandom_range(0, 1));
    snap();
    start4(t0);
    wait_rdy4(5000, tr, ok);
    chk("ovf_rdy_seen", ok, 1);
    chk("ovf_latency", tr - t0, run_lat(4, w));
    chk("ovf_flag", b4.ERR_OVF, 1);
    chk("ovf_no_tmo", b4.ERR_TMO, 0);
    repeat (3) @(negedge clk);
    chk("ovf_sticky", b4.ERR_OVF, 1);
    chk("ovf_dest_en", ndest - base_dest, 15);
    chk("ovf_invariants", nviol - base_viol, 0);
    ovf_at = 0;

    // Withheld ACK_SUM: watchdog expiry on the 255th WAIT cycle of the first op.
    hold = 1'b1;
    snap();
    start4(t0);
    chk("start_clears_ovf", b4.ERR_OVF, 0);
    repeat (257) @(negedge clk);
    chk("tmo_not_yet", b4.ERR_TMO, 0);
    @(negedge clk);
    chk("tmo_set", b4.ERR_TMO, 1);
    chk("tmo_rewind_no_pulse", b4.CLK_CDIR, 0);
    wait_rdy4(100, tr, ok);
    chk("tmo_rdy_seen", ok, 1);
    chk("tmo_latency", tr - t0, 1 + 2 + 255 + 1 + 1);
    @(negedge clk);
    chk("tmo_no_dest", ndest - base_dest, 0);
    chk("tmo_one_begin", nbeg - base_beg, 1);
    repeat (40) @(negedge clk);
    hold = 1'b0;

    // Start with a nonzero counter is ignored; error flags untouched.
    force7 = 1'b1;
    @(negedge clk);
    force7 = 1'b0;
    chk("force7_cnt", b4.CONT_ITERA, 7);
    snap();
    b4.BEG_CORDIC = 1'b1;
    @(negedge clk);
    b4.BEG_CORDIC = 1'b0;
    repeat (5) @(negedge clk);
    chk("cnt7_idle", b4.BUSY, 0);
    chk("cnt7_no_load", nreg3 - base_reg3, 0);
    chk("cnt7_tmo_kept", b4.ERR_TMO, 1);

    // Reset mid-op, then a fresh run.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    fpu_w = 2;
    start4(t0);
    repeat (20) @(negedge clk);
    chk("pre_rst_busy", b4.BUSY, 1);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rst_outputs_%0d", i), 64'(outs4()), 0);
    end
    rst = 1'b0;
    chk("rst_cnt_cleared", b4.CONT_ITERA, 0);
    @(negedge clk);
    snap();
    start4(t0);
    chk("post_rst_en_reg3", b4.EN_REG3, 1);
    wait_rdy4(5000, tr, ok);
    chk("post_rst_latency", tr - t0, run_lat(4, 2));
    chk("post_rst_cnt", b4.CONT_ITERA, 0);

    // N_ITER=32: single REWIND cycle, no rewind pulse.
    @(negedge clk);
    base_cdir = ncdir32;
    b32.BEG_CORDIC = 1'b1;
    t0 = cyc;
    @(negedge clk);
    b32.BEG_CORDIC = 1'b0;
    ok = 1'b0; tr = -1; prev = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (b32.RDY) begin ok = 1'b1; tr = cyc; break; end
      prev = b32.CLK_CDIR;
      @(negedge clk);
    end
    chk("n32_rdy_seen", ok, 1);
    chk("n32_latency", tr - t0, run_lat(32, 1));
    chk("n32_cnt_at_rdy", b32.CONT_ITERA, 0);
    chk("n32_rewind_no_pulse", prev, 0);
    @(negedge clk);
    chk("n32_clk_cdir", ncdir32 - base_cdir, 32);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
